waveform_gen: RTL and testbench

//  Consumer end of the waveform-select interface: takes the 2-bit waveform code
//  (00 square, 01 triangle, 10 sawtooth, 11 reserved) and produces unsigned audio

---
 rtl/synth_pkg.sv | 14 +
 rtl/phase_accumulator.sv | 34 +++
 rtl/waveform_gen.sv | 75 +++++++
 tb/tb_waveform_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: waveform codes and default widths shared by the synth control and sample blocks
package synth_pkg;

   typedef enum logic [1:0] {
      WAVE_SQUARE   = 2'b00,
      WAVE_TRIANGLE = 2'b01,
      WAVE_SAWTOOTH = 2'b10,
      WAVE_RSVD     = 2'b11
   } waveform_t;

   localparam int PHASE_W_DEF = 24;
   localparam int OUT_W_DEF   = 12;

endpackage

// File: rtl/phase_accumulator.sv
// phase_accumulator: modulo-2^PHASE_W phase register with clear, advance and wrap flag
module phase_accumulator
   import synth_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               adv,
   input  logic               clr,
   input  logic [PHASE_W-1:0] inc,
   output logic [PHASE_W-1:0] phase_nxt,
   output logic               wrap
);

   logic [PHASE_W-1:0] phase_q, phase_d, sum;
   logic               carry;

   // next phase: clear beats advance; carry out of the add marks a period wrap
   always_comb begin
      {carry, sum} = {1'b0, phase_q} + {1'b0, inc};
      phase_d      = clr ? '0 : adv ? sum : phase_q;
   end

   assign phase_nxt = phase_d;
   assign wrap      = adv & ~clr & carry;

   // phase register
   always_ff @(posedge clk) begin
      if (rst) phase_q <= '0;
      else     phase_q <= phase_d;
   end

endmodule

// File: rtl/waveform_gen.sv
// waveform_gen: phase-accumulator oscillator with wrap-aligned waveform switching
module waveform_gen
   import synth_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int OUT_W   = OUT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ena,
   input  logic [1:0]         waveform_in,
   input  logic [PHASE_W-1:0] phase_inc,
   input  logic               sample_tick,
   input  logic               phase_sync,
   output logic [OUT_W-1:0]   sample_out,
   output logic               sample_valid,
   output logic [1:0]         wave_active
);

   waveform_t          pending_q, pending_d, active_q, active_d, wave_in;
   logic [OUT_W-1:0]   sample_q, sample_d;
   logic               valid_q, valid_d;
   logic               tick, sync, wrap;
   logic [PHASE_W-1:0] phase_nxt;

   function automatic logic [OUT_W-1:0] shape(input waveform_t w, input logic [PHASE_W-1:0] p);
      logic [OUT_W-1:0] t;
      t = p[PHASE_W-2 -: OUT_W];
      return w == WAVE_SQUARE   ? {OUT_W{p[PHASE_W-1]}} :
             w == WAVE_SAWTOOTH ? p[PHASE_W-1 -: OUT_W] :
             w == WAVE_TRIANGLE ? (p[PHASE_W-1] ? ~t : t) : '0;
   endfunction

   assign wave_in = waveform_t'(waveform_in);
   assign sync    = ena & phase_sync;
   assign tick    = ena & sample_tick & ~phase_sync;

   phase_accumulator #(.PHASE_W(PHASE_W)) u_acc (
      .clk       (clk),
      .rst       (rst),
      .adv       (tick),
      .clr       (sync),
      .inc       (phase_inc),
      .phase_nxt (phase_nxt),
      .wrap      (wrap)
   );

   // waveform commit on wrap or sync, sample shaped from the phase being loaded
   always_comb begin
      pending_d = (ena && wave_in != WAVE_RSVD) ? wave_in : pending_q;
      active_d  = (sync || wrap) ? pending_q : active_q;
      valid_d   = tick | sync;
      sample_d  = valid_d ? shape(active_d, phase_nxt) : sample_q;
   end

   // waveform state and registered sample outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= WAVE_SQUARE;
         active_q  <= WAVE_SQUARE;
         sample_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         active_q  <= active_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign wave_active  = active_q;

endmodule

// File: tb/tb_waveform_gen.sv
// tb_waveform_gen: scoreboard bench for waveform_gen against a behavioural oscillator model
module tb_waveform_gen;

   logic        clk = 1'b0;
   logic        rst, ena, sample_tick, phase_sync;
   logic [1:0]  waveform_in;
   logic [23:0] phase_inc;
   logic [11:0] sample_out;
   logic        sample_valid;
   logic [1:0]  wave_active;

   int          n_vec = 0;
   int          n_err = 0;
   logic [11:0] sbq[$];
   logic [23:0] m_phase;
   logic [1:0]  m_pend, m_act;
   logic [11:0] m_samp;
   logic        m_val;

   waveform_gen dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .waveform_in  (waveform_in),
      .phase_inc    (phase_inc),
      .sample_tick  (sample_tick),
      .phase_sync   (phase_sync),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .wave_active  (wave_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] ref_sample(input logic [1:0] w, input logic [23:0] p);
      int t;
      t = int'((p >> 11) & 24'hFFF);
      case (w)
         2'b00:   return p[23] ? 12'hFFF : 12'h000;
         2'b10:   return 12'(p >> 12);
         2'b01:   return p[23] ? 12'(4095 - t) : 12'(t);
         default: return 12'h000;
      endcase
   endfunction

   task automatic step(input logic t, input logic s, input logic [1:0] w,
                       input logic en = 1'b1, input logic r = 1'b0);
      logic [24:0] sum;
      rst = r; ena = en; sample_tick = t; phase_sync = s; waveform_in = w;
      if (r) begin
         m_phase = '0; m_pend = 2'b00; m_act = 2'b00; m_samp = '0; m_val = 1'b0;
         sbq.delete();
      end else if (en) begin
         m_val = t | s;
         if (s) begin
            m_phase = '0;
            m_act   = m_pend;
         end else if (t) begin
            sum     = {1'b0, m_phase} + {1'b0, phase_inc};
            m_phase = sum[23:0];
            if (sum[24]) m_act = m_pend;
         end
         if (m_val) begin
            m_samp = ref_sample(m_act, m_phase);
            sbq.push_back(m_samp);
         end
         if (w != 2'b11) m_pend = w;
      end else begin
         m_val = 1'b0;
      end
      @(posedge clk);
      #1;
      check("valid", sample_valid, m_val);
      if (m_val) check("sample", sample_out, sbq.pop_front());
      else       check("hold", sample_out, m_samp);
      check("active", wave_active, m_act);
   endtask

   initial begin
      phase_inc = 24'h100000;
      step(0, 0, 2'b00, 1, 1);
      step(0, 0, 2'b00, 1, 1);
      check("rst_sample", sample_out, 12'h000);
      check("rst_active", wave_active, 2'b00);
      // sawtooth requested: square until first wrap, then sawtooth ramp
      for (int i = 1; i <= 32; i++) begin
         step(1, 0, 2'b10);
         if (i == 15) check("t1_act15", wave_active, 2'b00);
         if (i == 16) check("t1_act16", wave_active, 2'b10);
         if (i == 17) check("t1_saw1", sample_out, 12'h100);
         if (i == 31) check("t1_saw15", sample_out, 12'hF00);
         step(0, 0, 2'b10);
      end
      // back to square
      for (int i = 1; i <= 32; i++) begin
         step(1, 0, 2'b00);
         if (i == 24) check("sq8", sample_out, 12'hFFF);
         if (i == 23) check("sq7", sample_out, 12'h000);
      end
      // triangle
      for (int i = 1; i <= 32; i++) begin
         step(1, 0, 2'b01);
         if (i == 17) check("tri1", sample_out, 12'h200);
         if (i == 24) check("tri8", sample_out, 12'hFFF);
         if (i == 25) check("tri9", sample_out, 12'hDFF);
         if (i == 31) check("tri15", sample_out, 12'h1FF);
         if (i == 32) check("tri16", sample_out, 12'h000);
      end
      // square via sync, sawtooth requested mid-period
      step(0, 0, 2'b00);
      step(0, 1, 2'b00);
      for (int i = 1; i <= 16; i++) begin
         step(1, 0, i >= 3 ? 2'b10 : 2'b00);
         if (i == 15) check("mid_sq15", sample_out, 12'hFFF);
      end
      check("mid_act", wave_active, 2'b10);
      // reserved code never disturbs pending
      for (int i = 1; i <= 16; i++) step(1, 0, 2'b11);
      step(0, 1, 2'b11);
      check("rsvd_act", wave_active, 2'b10);
      // sync beats a simultaneous tick
      step(0, 0, 2'b01);
      for (int i = 0; i < 5; i++) step(1, 0, 2'b01);
      step(1, 1, 2'b01);
      check("sync_sample", sample_out, 12'h000);
      check("sync_act", wave_active, 2'b01);
      step(0, 0, 2'b01);
      // ena low freezes everything
      for (int i = 0; i < 3; i++) step(1, 0, 2'b00);
      for (int i = 0; i < 5; i++) step(1, 1, 2'b10, 0);
      // reset mid-period
      step(1, 0, 2'b10, 1, 1);
      check("rst2_sample", sample_out, 12'h000);
      check("rst2_active", wave_active, 2'b00);
      // zero increment: no wrap, commit only by sync
      phase_inc = 24'h0;
      for (int i = 0; i < 4; i++) step(1, 0, 2'b10);
      step(0, 1, 2'b10);
      // random mix
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: phase_inc = 24'h100000;
            1: phase_inc = 24'hFFFFFF;
            2: phase_inc = 24'h0;
            default: phase_inc = 24'($urandom);
         endcase
         step(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, 2'($urandom),
              $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
